// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the game_timer block.
//   t_tmr_state : per-channel state (idle, counting, expired one-shot)
//   f_div       : prescaler divide ratio from clock and tick frequencies
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } t_tmr_state;

  // Returns 0 for a zero tick rate so the caller's range check flags it.
  function automatic int unsigned f_div(input int unsigned clk_hz, input int unsigned tick_hz);
    return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/game_timer_prescaler.sv
// timer_prescaler: free-running divider producing a one-cycle tick every DIV clocks.
// Ports:
//   clk_50M  in  system clock
//   i_Reset  in  synchronous active-high reset (counter back to 0)
//   o_Tick   out high while the divider holds DIV-1
module timer_prescaler
  import game_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 2_000
) (
  input  logic clk_50M,
  input  logic i_Reset,
  output logic o_Tick
);

  localparam int unsigned DIV = f_div(CLK_HZ, TICK_HZ);
  localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  // DIV must be an exact integer ratio of at least 2.
  if (DIV < 2 || (DIV * TICK_HZ) != CLK_HZ) begin : g_bad_div
    $error("timer_prescaler: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_Tick = (r_cnt == LAST);

endmodule

// File: rtl/game_timer.sv
// game_timer: multi-channel programmable tick timer for the BlackJack control path.
// One shared prescaler tick drives NUM_CH independent one-shot/periodic channels.
// Optional feature macro: GAME_TIMER_PAUSE_EN adds i_Pause (per-channel tick freeze).
// Ports:
//   clk_50M     in   system clock
//   i_Reset     in   synchronous active-high reset
//   i_Start     in   per-channel start/restart pulse
//   i_Zero      in   per-channel clear back to idle
//   i_Periodic  in   per-channel auto-reload select
//   i_Pause     in   per-channel tick freeze (only with GAME_TIMER_PAUSE_EN)
//   i_Limit     in   per-channel terminal count, ch0 in LSBs
//   o_Count     out  per-channel tick count
//   o_Done      out  per-channel one-cycle expiry pulse
//   o_Expired   out  per-channel sticky expiry flag
//   o_Tick      out  shared prescaler tick
module game_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 2_000,
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned NUM_CH  = 2
) (
  input  logic                    clk_50M,
  input  logic                    i_Reset,
  input  logic [NUM_CH-1:0]       i_Start,
  input  logic [NUM_CH-1:0]       i_Zero,
  input  logic [NUM_CH-1:0]       i_Periodic,
`ifdef GAME_TIMER_PAUSE_EN
  input  logic [NUM_CH-1:0]       i_Pause,
`endif
  input  logic [NUM_CH*WIDTH-1:0] i_Limit,
  output logic [NUM_CH*WIDTH-1:0] o_Count,
  output logic [NUM_CH-1:0]       o_Done,
  output logic [NUM_CH-1:0]       o_Expired,
  output logic                    o_Tick
);

  if (NUM_CH < 1) begin : g_bad_ch
    $error("game_timer: NUM_CH must be >= 1");
  end

  logic              w_tick;
  logic [NUM_CH-1:0] w_pause;

`ifdef GAME_TIMER_PAUSE_EN
  assign w_pause = i_Pause;
`else
  assign w_pause = '0;
`endif

  timer_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_prescaler (
    .clk_50M (clk_50M),
    .i_Reset (i_Reset),
    .o_Tick  (w_tick)
  );

  assign o_Tick = w_tick;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    t_tmr_state       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] w_limit, w_eff_limit;
    logic [WIDTH:0]   w_count_inc;
    logic             r_done, w_done_nxt;
    logic             r_expired, w_expired_nxt;
    logic             w_tick_ch;

    assign w_limit     = i_Limit[g*WIDTH +: WIDTH];
    // A limit of 0 behaves as 1 so a started channel always expires.
    assign w_eff_limit = (w_limit == '0) ? WIDTH'(1) : w_limit;
    // One extra bit keeps the >= compare exact even at the top of the range.
    assign w_count_inc = {1'b0, r_count} + (WIDTH + 1)'(1);
    assign w_tick_ch   = w_tick & ~w_pause[g];

    // Priority below reset: zero, then start, then tick.
    always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_done_nxt    = 1'b0;
      w_expired_nxt = r_expired;
      if (i_Zero[g]) begin
        w_state_nxt   = ST_IDLE;
        w_count_nxt   = '0;
        w_expired_nxt = 1'b0;
      end else if (i_Start[g]) begin
        w_state_nxt   = ST_RUN;
        w_count_nxt   = '0;
        w_expired_nxt = 1'b0;
      end else if (r_state == ST_RUN && w_tick_ch) begin
        if (w_count_inc >= {1'b0, w_eff_limit}) begin
          w_done_nxt    = 1'b1;
          w_expired_nxt = 1'b1;
          if (i_Periodic[g]) begin
            w_count_nxt = '0;
          end else begin
            w_state_nxt = ST_DONE;
            w_count_nxt = w_eff_limit;
          end
        end else begin
          w_count_nxt = w_count_inc[WIDTH-1:0];
        end
      end
    end

    always_ff @(posedge clk_50M) begin
      if (i_Reset) begin
        r_state   <= ST_IDLE;
        r_count   <= '0;
        r_done    <= 1'b0;
        r_expired <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_count   <= w_count_nxt;
        r_done    <= w_done_nxt;
        r_expired <= w_expired_nxt;
      end
    end

    assign o_Count[g*WIDTH +: WIDTH] = r_count;
    assign o_Done[g]                 = r_done;
    assign o_Expired[g]              = r_expired;
  end

endmodule
